instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
// - Boot-time writer for the byte-addressed instruction memory: receives a byte stream over valid/ready,
//   writes it byte-by-byte at BASE_ADDR upward, and holds the CPU in reset until the image is complete.
// - Byte order matches the fetch side: the first stream byte of each word lands at the lowest address
//   (the fetch-side MSB), so the host streams instructions MSB-first.
// PARAMETERS
// - ADDRESS_WIDTH  32            memory write-address width
// - DATA_WIDTH     8             stream/memory byte width
// - BASE_ADDR      32'hBFC00000  address of first payload byte
// - MEM_BYTES      4096          capacity in bytes; longer images are rejected
// PORTS
// - clk       in   1   clock, all logic on rising edge
// - rst       in   1   synchronous active-high reset
// - start     in   1   begin/restart a load (sampled in IDLE, DONE, ERR only)
// - in_valid  in   1   host byte valid
// - in_data   in   8   host byte
// - in_ready  out  1   loader accepts in_data this cycle
// - mem_we    out  1   write strobe to instruction RAM
// - mem_wa    out  32  write byte address
// - mem_wd    out  8   write byte data
// - cpu_rst   out  1   hold-CPU-in-reset; high until load completes
// - busy      out  1   high in LEN/DATA/CHK
// - done      out  1   image loaded successfully (level)
// - err       out  1   load rejected (level)
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=0, mem_we=0, mem_wa=BASE_ADDR, mem_wd=0, cpu_rst=1, busy=0, done=0, err=0.
// - Handshake: byte transferred on cycle where in_valid && in_ready; in_ready is a pure function of state
//   (1 in LEN/DATA/CHK, else 0), never depends on in_valid. Host may stall indefinitely.
// - FSM: IDLE -start-> LEN. LEN collects 4 bytes, big-endian, into 32-bit len.
//   After 4th byte: len > MEM_BYTES -> ERR; len == 0 -> DONE (or CHK if CHECKSUM_EN); else -> DATA.
//   DATA: byte k (0-based) written to BASE_ADDR+k; after byte len-1 -> DONE (or CHK).
//   DONE/ERR: hold; start -> LEN with done/err cleared and cpu_rst=1 that same next cycle.
// - Write latency: byte accepted in cycle N -> mem_we=1 with mem_wa/mem_wd in cycle N+1, for exactly
//   one cycle; back-to-back accepts give back-to-back writes. No writes in LEN/CHK.
// - cpu_rst falls and done rises together, in the cycle after the final payload write strobe
//   (or, for len==0, the cycle after FSM enters DONE); never before the last mem_we.
// - Counter: 32-bit byte offset, cleared on entry to LEN; address never wraps (len <= MEM_BYTES).
// - start while busy is ignored. Reset mid-load aborts immediately: back to IDLE, cpu_rst=1,
//   partially written memory is left as-is.
// CONFIGURATION
// - CHECKSUM_EN defined: after payload, state CHK accepts one extra byte = XOR of all payload bytes
//   (0x00 for len==0). Match -> DONE; mismatch -> ERR, cpu_rst stays 1.
// - CHECKSUM_EN undefined: no CHK state; DATA (or len==0) goes straight to DONE; no trailer byte consumed.
// TESTING
// - Reset, start, stream 00 00 00 04, 13 05 00 00 -> writes BFC00000..BFC00003 = 13,05,00,00; done=1,
//   cpu_rst=0 one cycle after last mem_we.
// - Same image with in_valid toggling every other cycle -> identical writes, one mem_we per accepted byte.
// - Length 00 00 10 01 (4097) -> err=1 after 4th byte, no mem_we, cpu_rst=1, in_ready=0.
// - Length 0 -> done=1 with no writes (CHECKSUM_EN: after trailer 00).
// - rst asserted after 2 of 8 payload bytes -> IDLE, cpu_rst=1, done=0; restart loads full image.
// - CHECKSUM_EN: payload 13 05 00 00 with trailer 16 -> done; trailer 17 -> err, cpu_rst=1.

Source files
------------

// File: rtl/instr_loader_if.sv
// Boot-loader bus: host byte stream in (start/valid/ready/data), instruction
// RAM byte-write port out, plus CPU-reset hold and load status levels.
interface instr_loader_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic                     start;
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic                     cpu_rst;
  logic                     busy;
  logic                     done;
  logic                     err;

  // host / boot controller side
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_wa, mem_wd, cpu_rst, busy, done, err
  );

  // loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_wa, mem_wd, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: boot-time writer for the byte-addressed instruction RAM.
// Stream format: 4-byte big-endian length, then <length> payload bytes that are
// written to BASE_ADDR upward (first byte at the lowest address). The CPU is
// held in reset until the whole image has been written.
// Optional feature macro CHECKSUM_EN: a trailer byte equal to the XOR of all
// payload bytes follows the payload; a mismatch rejects the image.
module instr_loader #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
  parameter int unsigned              MEM_BYTES     = 4096
) (
  input logic           clk,
  input logic           rst,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // Where the FSM goes once the payload (or an empty payload) is finished,
  // and whether the stream stays open for a trailer byte.
`ifdef CHECKSUM_EN
  localparam state_t PAYLOAD_END = S_CHK;
  localparam bit     END_ACTIVE  = 1'b1;
`else
  localparam state_t PAYLOAD_END = S_DONE;
  localparam bit     END_ACTIVE  = 1'b0;
`endif

  state_t          state;
  logic            active_q;   // high exactly in the stream-consuming states
  logic [31:0]     len_q;      // payload length, shifted in MSB-first
  logic [1:0]      len_cnt;    // length bytes received so far
  logic [31:0]     off_q;      // payload byte offset from BASE_ADDR
`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
`endif

  logic        accept;
  logic [31:0] len_full;

  // in_ready/busy depend only on state, never on in_valid
  assign bus.in_ready = active_q;
  assign bus.busy     = active_q;
  assign accept       = bus.in_valid && active_q;
  // length value including the byte being accepted now
  assign len_full     = (len_q << DATA_WIDTH) | 32'(bus.in_data);

  // Loader FSM with registered outputs; writes appear one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      active_q    <= 1'b0;
      bus.mem_we  <= 1'b0;
      bus.mem_wa  <= BASE_ADDR;
      bus.mem_wd  <= '0;
      bus.cpu_rst <= 1'b1;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      len_q       <= '0;
      len_cnt     <= '0;
      off_q       <= '0;
`ifdef CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            // (re)start: status cleared and CPU held in reset from the next cycle
            state       <= S_LEN;
            active_q    <= 1'b1;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.cpu_rst <= 1'b1;
            len_q       <= '0;
            len_cnt     <= '0;
            off_q       <= '0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
`endif
          end else if (state == S_DONE) begin
            // release lands one cycle after DONE is entered, i.e. after the last write
            bus.done    <= 1'b1;
            bus.cpu_rst <= 1'b0;
          end
        end
        S_LEN: begin
          if (accept) begin
            len_q   <= len_full;
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'd3) begin
              if (len_full > MEM_BYTES) begin
                state    <= S_ERR;
                active_q <= 1'b0;
                bus.err  <= 1'b1;
              end else if (len_full == 32'd0) begin
                state    <= PAYLOAD_END;
                active_q <= END_ACTIVE;
              end else begin
                state    <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            bus.mem_we <= 1'b1;
            bus.mem_wa <= BASE_ADDR + ADDRESS_WIDTH'(off_q);
            bus.mem_wd <= bus.in_data;
            off_q      <= off_q + 32'd1;
`ifdef CHECKSUM_EN
            csum_q     <= csum_q ^ bus.in_data;
`endif
            if (off_q == len_q - 32'd1) begin
              state    <= PAYLOAD_END;
              active_q <= END_ACTIVE;
            end
          end
        end
`ifdef CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            active_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              state <= S_DONE;
            end else begin
              state   <= S_ERR;
              bus.err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: randomized streams checked every cycle against a
// history-based reference model (outcome derived from the accepted byte list),
// plus hand-computed literal checks for the directed scenarios.
module tb_instr_loader;
  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int unsigned MEM  = 4096;
`ifdef CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) ifc ();

  instr_loader #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(8), .BASE_ADDR(BASE), .MEM_BYTES(MEM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A load is "active" from start until the byte history decides the outcome.
  bit          m_act, m_fin;
  logic [7:0]  got[$];
  logic [31:0] m_len;
  logic        e_ready, e_busy, e_we, e_cpu_rst, e_done, e_err;
  logic [31:0] e_wa;
  logic [7:0]  e_wd;

  always @(posedge clk) begin : model
    int n;
    logic [7:0] b, x;
    if (rst) begin
      m_act = 0; m_fin = 0; got.delete();
      e_ready = 0; e_busy = 0; e_we = 0; e_wa = BASE; e_wd = 0;
      e_cpu_rst = 1; e_done = 0; e_err = 0;
    end else begin
      e_we = 0;
      if (!m_act) begin
        if (ifc.start) begin
          m_act = 1; m_fin = 0; got.delete();
          e_done = 0; e_err = 0; e_cpu_rst = 1;
        end else if (m_fin) begin
          e_done = 1; e_cpu_rst = 0;
        end
      end else if (ifc.in_valid) begin
        b = ifc.in_data;
        got.push_back(b);
        n = got.size();
        if (n == 4) begin
          m_len = {got[0], got[1], got[2], got[3]};
          if (m_len > MEM) begin m_act = 0; e_err = 1; end
          else if (m_len == 0 && !CK) begin m_act = 0; m_fin = 1; end
        end else if (n > 4 && n <= 4 + int'(m_len)) begin
          e_we = 1; e_wa = BASE + 32'(n - 5); e_wd = b;
          if (n == 4 + int'(m_len) && !CK) begin m_act = 0; m_fin = 1; end
        end else if (n > 4) begin
          x = 0;
          for (int i = 4; i < n - 1; i++) x = x ^ got[i];
          m_act = 0;
          if (b == x) m_fin = 1; else e_err = 1;
        end
      end
      e_ready = m_act; e_busy = m_act;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("in_ready", ifc.in_ready, e_ready);
    chk("busy",     ifc.busy,     e_busy);
    chk("mem_we",   ifc.mem_we,   e_we);
    chk("cpu_rst",  ifc.cpu_rst,  e_cpu_rst);
    chk("done",     ifc.done,     e_done);
    chk("err",      ifc.err,      e_err);
    if (e_we) begin
      chk("mem_wa", ifc.mem_wa, e_wa);
      chk("mem_wd", ifc.mem_wd, e_wd);
    end
  end

  // ---------------- DUT write capture ----------------
  logic [7:0] dmem [0:4095];
  int cyc = 0, wr_cnt = 0, last_we_cyc = 0, done_cyc = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    logic [31:0] off;
    cyc++;
    if (ifc.mem_we) begin
      off = ifc.mem_wa - BASE;
      if (off < MEM) dmem[off[11:0]] = ifc.mem_wd;
      wr_cnt++;
      last_we_cyc = cyc;
    end
    if (ifc.done && !done_prev) done_cyc = cyc;
    done_prev = ifc.done;
  end

  // ---------------- stimulus ----------------
  logic [7:0] img[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit rs);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); ifc.in_valid = 1'b0; ifc.in_data = 8'($urandom);
    end
    @(negedge clk);
    ifc.in_valid = 1'b1; ifc.in_data = b;
    ifc.start = rs && ($urandom_range(0, 3) == 0);   // ignored while busy
    t = 0;
    while (!ifc.in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic idle();
    @(negedge clk); ifc.in_valid = 1'b0; ifc.start = 1'b0;
  endtask

  task automatic load(input int gmin, input int gmax, input bit rs);
    pulse_start();
    foreach (img[i]) send(img[i], $urandom_range(gmin, gmax), rs);
    idle();
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(ifc.done || ifc.err) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_end: done/err never rose, required one of them");
    end
    tick(1);
  endtask

  task automatic build_rand(input int len, input bit bad_ck);
    logic [7:0]  x = 8'h00;
    logic [7:0]  b;
    logic [31:0] l = 32'(len);
    img.delete();
    img.push_back(l[31:24]); img.push_back(l[23:16]);
    img.push_back(l[15:8]);  img.push_back(l[7:0]);
    if (len <= int'(MEM)) begin
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom); img.push_back(b); x = x ^ b;
      end
      if (CK) img.push_back(bad_ck ? (x ^ 8'h01) : x);
    end
  endtask

  initial begin
    int len;
    bit bad;
    ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = 8'h00;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // reset state
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_mem_we",   ifc.mem_we,   0);
    chk("rst_mem_wa",   ifc.mem_wa,   32'hBFC00000);
    chk("rst_mem_wd",   ifc.mem_wd,   0);
    chk("rst_cpu_rst",  ifc.cpu_rst,  1);
    chk("rst_busy",     ifc.busy,     0);
    chk("rst_done",     ifc.done,     0);
    chk("rst_err",      ifc.err,      0);

    // 4-byte image, continuous valid
    img = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h05, 8'h00, 8'h00};
    if (CK) img.push_back(8'h16);
    for (int i = 0; i < 4; i++) dmem[i] = 8'hAA;
    wr_cnt = 0;
    load(0, 0, 0);
    wait_end();
    chk("t1_done", ifc.done, 1);
    chk("t1_cpu_rst", ifc.cpu_rst, 0);
    chk("t1_writes", wr_cnt, 4);
    chk("t1_m0", dmem[0], 8'h13);
    chk("t1_m1", dmem[1], 8'h05);
    chk("t1_m2", dmem[2], 8'h00);
    chk("t1_m3", dmem[3], 8'h00);
    chk("t1_done_lag", done_cyc - last_we_cyc, 1);

    // same image, valid toggling every other cycle (restart from DONE)
    for (int i = 0; i < 4; i++) dmem[i] = 8'hAA;
    wr_cnt = 0;
    load(1, 1, 0);
    wait_end();
    chk("t2_done", ifc.done, 1);
    chk("t2_writes", wr_cnt, 4);
    chk("t2_m0", dmem[0], 8'h13);
    chk("t2_m1", dmem[1], 8'h05);
    chk("t2_done_lag", done_cyc - last_we_cyc, 1);

    // oversize length 4097
    img = '{8'h00, 8'h00, 8'h10, 8'h01};
    wr_cnt = 0;
    load(0, 0, 0);
    tick(3);
    chk("t3_err", ifc.err, 1);
    chk("t3_cpu_rst", ifc.cpu_rst, 1);
    chk("t3_in_ready", ifc.in_ready, 0);
    chk("t3_done", ifc.done, 0);
    chk("t3_writes", wr_cnt, 0);

    // zero length (restart from ERR)
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    if (CK) img.push_back(8'h00);
    wr_cnt = 0;
    load(0, 0, 0);
    wait_end();
    chk("t4_done", ifc.done, 1);
    chk("t4_err", ifc.err, 0);
    chk("t4_cpu_rst", ifc.cpu_rst, 0);
    chk("t4_writes", wr_cnt, 0);

    // reset after 2 of 8 payload bytes, then full reload
    build_rand(8, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) send(img[i], 0, 0);
    @(negedge clk); rst = 1'b1; ifc.in_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("t5_cpu_rst", ifc.cpu_rst, 1);
    chk("t5_done", ifc.done, 0);
    chk("t5_busy", ifc.busy, 0);
    wr_cnt = 0;
    load(0, 2, 0);
    wait_end();
    chk("t5_done_after", ifc.done, 1);
    chk("t5_writes", wr_cnt, 8);

`ifdef CHECKSUM_EN
    // wrong checksum trailer
    img = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h05, 8'h00, 8'h00, 8'h17};
    load(0, 0, 0);
    wait_end();
    chk("t6_err", ifc.err, 1);
    chk("t6_cpu_rst", ifc.cpu_rst, 1);
    chk("t6_done", ifc.done, 0);
`endif

    // full-capacity image
    build_rand(int'(MEM), 0);
    wr_cnt = 0;
    load(0, 0, 0);
    wait_end();
    chk("t7_done", ifc.done, 1);
    chk("t7_writes", wr_cnt, int'(MEM));

    // random images, gaps and ignored start pulses
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 5))
        0:       len = 0;
        1:       len = int'(MEM) + 1 + int'($urandom_range(0, 3000));
        default: len = int'($urandom_range(1, 40));
      endcase
      bad = CK && ($urandom_range(0, 2) == 0);
      build_rand(len, bad);
      wr_cnt = 0;
      load(0, 2, 1);
      wait_end();
      chk("rnd_done", ifc.done, (len <= int'(MEM)) && !bad);
      chk("rnd_writes", wr_cnt, (len <= int'(MEM)) ? len : 0);
    end

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
